sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO and successor to the 4x8 UART FIFO. Width and depth are generic. Adds an occupancy count, programmable almost-full/almost-empty flags, overflow/underflow error pulses, and defined push+pop behaviour at full. Sits between the UART RX/TX datapaths and the command/loopback logic, and is reusable for any byte or word stream in the design.

Parameters:
BIT_WIDTH, 8, data width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active-low
push  in  1  write request
pop  in  1  read request
push_data  in  BIT_WIDTH  write data
pop_data  out  BIT_WIDTH  read data (head of FIFO)
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  one-cycle pulse: push rejected
underflow  out  1  one-cycle pulse: pop rejected

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n. All state is cleared immediately on rst_n low, independent of clk.
- Reset values: wptr=0, rptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0 (unless AF_THRESH==0, which is illegal), overflow=0, underflow=0, pop_data=mem[0] (without macro) or 0 (with macro). Memory contents are not reset.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count is a register, not derived from the pointers.
- Flags full, empty, almost_* are decoded combinationally from the registered count. No combinational path from push/pop to any flag.
- Acceptance rules, evaluated on the current registered state:
  - push_acc = push & (~full | pop)
  - pop_acc = pop & ~empty
- On push_acc: mem[wptr] <= push_data; wptr <= wptr+1.
- On pop_acc: rptr <= rptr+1.
- count update:
  - push_acc only: count+1
  - pop_acc only: count-1
  - both, or neither: count unchanged
- Full with push+pop: both accepted. The head is popped and the new word is written into the freed slot. count stays at DEPTH and no overflow is reported.
- Empty with push+pop: push accepted, pop rejected. count becomes 1 and underflow pulses.
- overflow <= push & ~push_acc, registered, high for the cycle after the rejected push. Stored data and pointers are untouched.
- underflow <= pop & ~pop_acc, same timing rule.
- Read latency without macro (show-ahead): pop_data = mem[rptr] combinationally. The head word is valid whenever empty=0, and pop consumes it at the clock edge.
- Reset mid-operation: contents are discarded, pointers return to 0, and pending request inputs are ignored while rst_n is low.
- First edge after release: behaves as from an empty FIFO.

Optional Feature:
Macro FIFO_REG_OUT_EN.
- Defined: pop_data is a register, loaded with mem[rptr] on each pop_acc edge and held otherwise. Data popped at edge N is visible after edge N, i.e. one cycle read latency. Reset value is 0. Rejected pops leave pop_data unchanged.
- Undefined: show-ahead combinational read as described above.
- Flags, count and acceptance rules are identical in both builds.

Test Plan:
1. Reset then idle. Hold rst_n=0 for 3 cycles, release -> empty=1, full=0, count=0, almost_empty=1, overflow=underflow=0.
2. Fill (DEPTH=16, AF_THRESH=14, AE_THRESH=2). Push 0x00..0x0F, then push 0xAA -> count=16, full=1, almost_full from count=14 onward, 17th push gives overflow=1 for one cycle, and 0xAA is never read out.
3. Drain and wrap.
   - Pop 16 times -> data 0x00..0x0F in order, empty=1 after the last pop.
   - Extra pop -> underflow pulse, and count stays 0.
   - Push 0x20..0x27, pop all 8 -> correct order across the pointer wrap.
4. Simultaneous at full. From full with head 0x00, push=pop=1 with 0x55 for one cycle -> count stays 16, no overflow. Subsequent drain yields 0x01..0x0F then 0x55.
5. Simultaneous at empty. From empty, push=pop=1 with 0x33 -> count=1, underflow pulses, next pop returns 0x33.
6. Async reset mid-stream. Push 5 words, assert rst_n low between clock edges -> flags and count reset immediately without a clock edge. After release, empty=1. Repeat the tests under FIFO_REG_OUT_EN, checking 1-cycle pop_data latency.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, almost-full/empty flags and overflow/underflow pulses.
// Define FIFO_REG_OUT_EN for a registered pop_data (one-cycle read latency); default is a show-ahead read.
module sync_fifo_param #(
    parameter int BIT_WIDTH = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [BIT_WIDTH-1:0]     i_push_data,
    output logic [BIT_WIDTH-1:0]     o_pop_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_almost_full,
    output logic                     o_almost_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic                     o_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [BIT_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [CW-1:0]        r_count;
    logic                 r_overflow;
    logic                 r_underflow;

    logic w_full;
    logic w_empty;
    logic w_push_acc;
    logic w_pop_acc;

    // Flags come only from the registered count, never from push/pop.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // At full a simultaneous pop frees the slot the push lands in.
    assign w_push_acc = i_push & (~w_full | i_pop);
    assign w_pop_acc  = i_pop & ~w_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_acc) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop_acc) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_overflow  <= i_push & ~w_push_acc;
            r_underflow <= i_pop & ~w_pop_acc;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (w_push_acc) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

`ifdef FIFO_REG_OUT_EN
    logic [BIT_WIDTH-1:0] r_pop_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pop_data <= '0;
        end else if (w_pop_acc) begin
            r_pop_data <= r_mem[r_rptr];
        end
    end

    assign o_pop_data = r_pop_data;
`else
    assign o_pop_data = r_mem[r_rptr];
`endif

    assign o_full         = w_full;
    assign o_empty        = w_empty;
    assign o_almost_full  = (r_count >= CW'(AF_THRESH));
    assign o_almost_empty = (r_count <= CW'(AE_THRESH));
    assign o_count        = r_count;
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (DEPTH=16, AF=14, AE=2); honours FIFO_REG_OUT_EN.
module tb_sync_fifo_param;

    logic       clk;
    logic       rstN;
    logic       push;
    logic       pop;
    logic [7:0] pushData;
    logic [7:0] popData;
    logic       full;
    logic       empty;
    logic       almostFull;
    logic       almostEmpty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int errors = 0;
    int checks = 0;

    sync_fifo_param #(
        .BIT_WIDTH (8),
        .DEPTH     (16),
        .AF_THRESH (14),
        .AE_THRESH (2)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rstN),
        .i_push         (push),
        .i_pop          (pop),
        .i_push_data    (pushData),
        .o_pop_data     (popData),
        .o_full         (full),
        .o_empty        (empty),
        .o_almost_full  (almostFull),
        .o_almost_empty (almostEmpty),
        .o_count        (count),
        .o_overflow     (overflow),
        .o_underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one request cycle from a falling edge; returns on the next falling edge.
    task automatic applyStimulus(input logic p, input logic q, input logic [7:0] d);
        push     = p;
        pop      = q;
        pushData = d;
        @(negedge clk);
        push     = 1'b0;
        pop      = 1'b0;
    endtask

    // Pop one word and compare it, respecting the read latency of the build.
    task automatic popExpect(input string tag, input logic [7:0] expected);
`ifdef FIFO_REG_OUT_EN
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput(tag, 32'(popData), 32'(expected));
`else
        checkOutput(tag, 32'(popData), 32'(expected));
        applyStimulus(1'b0, 1'b1, 8'h00);
`endif
    endtask

    task automatic checkIdleFlags(input string tag);
        checkOutput({tag, "_count"}, 32'(count), 32'(0));
        checkOutput({tag, "_empty"}, 32'(empty), 32'(1));
        checkOutput({tag, "_full"}, 32'(full), 32'(0));
        checkOutput({tag, "_aempty"}, 32'(almostEmpty), 32'(1));
        checkOutput({tag, "_afull"}, 32'(almostFull), 32'(0));
    endtask

    initial begin
        rstN     = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        pushData = 8'h00;

        // Reset then idle
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        checkIdleFlags("reset");
        checkOutput("reset_ovf", 32'(overflow), 32'(0));
        checkOutput("reset_unf", 32'(underflow), 32'(0));
`ifdef FIFO_REG_OUT_EN
        checkOutput("reset_popdata", 32'(popData), 32'(0));
`endif
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("idle_count", 32'(count), 32'(0));

        // Fill and overflow
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 8'(i));
            checkOutput("fill_count", 32'(count), 32'(i + 1));
            checkOutput("fill_afull", 32'(almostFull), 32'((i + 1) >= 14));
            checkOutput("fill_aempty", 32'(almostEmpty), 32'((i + 1) <= 2));
            checkOutput("fill_full", 32'(full), 32'((i + 1) == 16));
        end
`ifndef FIFO_REG_OUT_EN
        checkOutput("fill_head", 32'(popData), 32'(8'h00));
`endif
        applyStimulus(1'b1, 1'b0, 8'hAA);
        checkOutput("ovf_pulse", 32'(overflow), 32'(1));
        checkOutput("ovf_count", 32'(count), 32'(16));
        checkOutput("ovf_full", 32'(full), 32'(1));
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("ovf_clear", 32'(overflow), 32'(0));

        // Drain in order, then underflow
        for (int i = 0; i < 16; i++) begin
            popExpect("drain_data", 8'(i));
            checkOutput("drain_count", 32'(count), 32'(15 - i));
        end
        checkIdleFlags("drained");
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("unf_pulse", 32'(underflow), 32'(1));
        checkOutput("unf_count", 32'(count), 32'(0));
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("unf_clear", 32'(underflow), 32'(0));

        // Partial burst leaves pointers at 8 so the next fill wraps
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 8'(8'h20 + i));
        checkOutput("burst_count", 32'(count), 32'(8));
        for (int i = 0; i < 8; i++) popExpect("burst_data", 8'(8'h20 + i));
        checkOutput("burst_empty", 32'(empty), 32'(1));

        // Simultaneous push+pop at full
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 8'(i));
        checkOutput("refill_full", 32'(full), 32'(1));
`ifndef FIFO_REG_OUT_EN
        checkOutput("simfull_head", 32'(popData), 32'(8'h00));
`endif
        applyStimulus(1'b1, 1'b1, 8'h55);
        checkOutput("simfull_count", 32'(count), 32'(16));
        checkOutput("simfull_ovf", 32'(overflow), 32'(0));
        checkOutput("simfull_full", 32'(full), 32'(1));
`ifdef FIFO_REG_OUT_EN
        checkOutput("simfull_popdata", 32'(popData), 32'(8'h00));
`endif
        for (int i = 1; i < 16; i++) popExpect("simfull_drain", 8'(i));
        popExpect("simfull_last", 8'h55);
        checkOutput("simfull_empty", 32'(empty), 32'(1));

        // Simultaneous push+pop at empty
        applyStimulus(1'b1, 1'b1, 8'h33);
        checkOutput("simempty_count", 32'(count), 32'(1));
        checkOutput("simempty_unf", 32'(underflow), 32'(1));
        checkOutput("simempty_empty", 32'(empty), 32'(0));
`ifdef FIFO_REG_OUT_EN
        checkOutput("simempty_hold", 32'(popData), 32'(8'h55));
`endif
        popExpect("simempty_data", 8'h33);
        checkOutput("simempty_after", 32'(count), 32'(0));

        // Asynchronous reset mid-stream, requests held active during reset
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'(8'h40 + i));
        checkOutput("prereset_count", 32'(count), 32'(5));
        #2;
        rstN = 1'b0;
        #1;
        checkIdleFlags("asyncrst");
`ifdef FIFO_REG_OUT_EN
        checkOutput("asyncrst_popdata", 32'(popData), 32'(0));
`endif
        push     = 1'b1;
        pop      = 1'b1;
        pushData = 8'hEE;
        @(negedge clk);
        @(negedge clk);
        checkOutput("inrst_count", 32'(count), 32'(0));
        push = 1'b0;
        pop  = 1'b0;
        rstN = 1'b1;
        checkIdleFlags("release");
        applyStimulus(1'b1, 1'b0, 8'h77);
        checkOutput("postrst_count", 32'(count), 32'(1));
        popExpect("postrst_data", 8'h77);
        checkOutput("postrst_empty", 32'(empty), 32'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
